// File: rtl/snow64_mem_access_arbiter_pkg.sv
// Shared types and constants for the snow64 memory access arbiter.
package snow64_mem_access_arbiter_pkg;

  localparam int unsigned LineOffset = 5;

  typedef enum logic {
    Icache = 1'b0,
    Data   = 1'b1
  } requester_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  // Per-transaction control captured at grant time.
  typedef struct packed {
    requester_e id;
    logic       write;
  } grant_t;

endpackage

// File: rtl/snow64_mem_access_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the memory controller.
interface snow64_mem_access_arbiter_if #(
  parameter int unsigned WIDTH_ADDR = 64,
  parameter int unsigned WIDTH_LINE = 256
);
  logic                  in_icache_req_valid;
  logic [WIDTH_ADDR-1:0] in_icache_req_addr;
  logic                  out_icache_ack;
  logic [WIDTH_LINE-1:0] out_icache_rdata;

  logic                  in_data_req_valid;
  logic                  in_data_req_write;
  logic [WIDTH_ADDR-1:0] in_data_req_addr;
  logic [WIDTH_LINE-1:0] in_data_req_wdata;
  logic                  out_data_ack;
  logic [WIDTH_LINE-1:0] out_data_rdata;

  logic                  out_mem_req_valid;
  logic                  out_mem_req_write;
  logic [WIDTH_ADDR-1:0] out_mem_req_addr;
  logic [WIDTH_LINE-1:0] out_mem_req_wdata;
  logic                  in_mem_busy;
  logic                  in_mem_ack;
  logic [WIDTH_LINE-1:0] in_mem_rdata;

  // Arbiter side.
  modport slave (
    input  in_icache_req_valid, in_icache_req_addr,
    input  in_data_req_valid, in_data_req_write, in_data_req_addr, in_data_req_wdata,
    input  in_mem_busy, in_mem_ack, in_mem_rdata,
    output out_icache_ack, out_icache_rdata, out_data_ack, out_data_rdata,
    output out_mem_req_valid, out_mem_req_write, out_mem_req_addr, out_mem_req_wdata
  );

  // Environment side: caches plus memory controller.
  modport master (
    output in_icache_req_valid, in_icache_req_addr,
    output in_data_req_valid, in_data_req_write, in_data_req_addr, in_data_req_wdata,
    output in_mem_busy, in_mem_ack, in_mem_rdata,
    input  out_icache_ack, out_icache_rdata, out_data_ack, out_data_rdata,
    input  out_mem_req_valid, out_mem_req_write, out_mem_req_addr, out_mem_req_wdata
  );
endinterface

// File: rtl/snow64_rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester not granted last time wins.
module snow64_rr_arbiter2
  import snow64_mem_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       req_icache,
  input  logic       req_data,
  output logic       grant_valid,
  output requester_e grant_id
);

  requester_e last_q;

  always_comb begin
    grant_valid = req_icache | req_data;
    if (req_icache && req_data) begin
      grant_id = (last_q == Icache) ? Data : Icache;
    end else if (req_data) begin
      grant_id = Data;
    end else begin
      grant_id = Icache;
    end
  end

  // Reset to Icache so the data side wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= Icache;
    end else if (enable && grant_valid) begin
      last_q <= grant_id;
    end
  end

endmodule

// File: rtl/snow64_mem_access_arbiter.sv
// Serialises icache refills and data line loads/stores onto the single memory port.
module snow64_mem_access_arbiter
  import snow64_mem_access_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = 64,
  parameter int unsigned WIDTH_LINE = 256
) (
  input logic                        clk,
  input logic                        rst_n,
  snow64_mem_access_arbiter_if.slave bus
);

  localparam logic [WIDTH_ADDR-1:0] LineMask = ~WIDTH_ADDR'((1 << LineOffset) - 1);

  state_e                state_q, state_d;
  grant_t                cur_q;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [WIDTH_LINE-1:0] wdata_q;
  logic                  icache_ack_q, data_ack_q;
  logic [WIDTH_LINE-1:0] icache_rdata_q, data_rdata_q;

  logic       grant_valid;
  requester_e grant_id;
  logic       take, issue, done;

  // The requester being acked still shows its stale valid this cycle; mask it.
  snow64_rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state_q == StIdle),
    .req_icache (bus.in_icache_req_valid & ~icache_ack_q),
    .req_data   (bus.in_data_req_valid & ~data_ack_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          take    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!bus.in_mem_busy) begin
          issue   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.in_mem_ack) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      icache_ack_q   <= 1'b0;
      data_ack_q     <= 1'b0;
      icache_rdata_q <= '0;
      data_rdata_q   <= '0;
    end else begin
      icache_ack_q <= done && (cur_q.id == Icache);
      data_ack_q   <= done && (cur_q.id == Data);
      if (take) begin
        cur_q.id <= grant_id;
        if (grant_id == Data) begin
          cur_q.write <= bus.in_data_req_write;
          addr_q      <= bus.in_data_req_addr & LineMask;
          wdata_q     <= bus.in_data_req_wdata;
        end else begin
          cur_q.write <= 1'b0;
          addr_q      <= bus.in_icache_req_addr & LineMask;
          wdata_q     <= '0;
        end
      end
      if (done && (cur_q.id == Icache)) begin
        icache_rdata_q <= bus.in_mem_rdata;
      end
      // Write completions leave the data-side read line untouched.
      if (done && (cur_q.id == Data) && !cur_q.write) begin
        data_rdata_q <= bus.in_mem_rdata;
      end
    end
  end

  assign bus.out_mem_req_valid = issue;
  assign bus.out_mem_req_write = cur_q.write;
  assign bus.out_mem_req_addr  = addr_q;
  assign bus.out_mem_req_wdata = wdata_q;
  assign bus.out_icache_ack    = icache_ack_q;
  assign bus.out_icache_rdata  = icache_rdata_q;
  assign bus.out_data_ack      = data_ack_q;
  assign bus.out_data_rdata    = data_rdata_q;

endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// Self-checking bench for snow64_mem_access_arbiter: directed scenarios plus a randomized
// alternation run against a transaction-level model.
module tb_snow64_mem_access_arbiter;

  localparam int unsigned WA = 64;
  localparam int unsigned WL = 256;
  localparam logic [WA-1:0] AMask = ~64'h1f;

  typedef logic [WL-1:0] line_t;
  typedef logic [WA-1:0] addr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0, iack_cnt = 0, dack_cnt = 0, overlap_cnt = 0;

  snow64_mem_access_arbiter_if #(.WIDTH_ADDR(WA), .WIDTH_LINE(WL)) bus ();

  snow64_mem_access_arbiter #(.WIDTH_ADDR(WA), .WIDTH_LINE(WL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.out_mem_req_valid === 1'b1) strobe_cnt++;
    if (bus.out_icache_ack === 1'b1) iack_cnt++;
    if (bus.out_data_ack === 1'b1) dack_cnt++;
    if (bus.out_icache_ack === 1'b1 && bus.out_data_ack === 1'b1) overlap_cnt++;
  end

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic addr_t rand_addr();
    addr_t a;
    a = {$urandom, $urandom};
    return a;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_icache_req_valid = 1'b0;
    bus.in_icache_req_addr  = '0;
    bus.in_data_req_valid   = 1'b0;
    bus.in_data_req_write   = 1'b0;
    bus.in_data_req_addr    = '0;
    bus.in_data_req_wdata   = '0;
    bus.in_mem_busy         = 1'b0;
    bus.in_mem_ack          = 1'b0;
    bus.in_mem_rdata        = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the memory strobe; reports cycles waited.
  task automatic wait_strobe(input int limit, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < limit) begin
      if (bus.out_mem_req_valid === 1'b1) ok = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_icache_ack !== 1'b0) begin errors++; $display("FAIL reset_icache_ack got %b want 0", bus.out_icache_ack); end
    checks++; if (bus.out_data_ack !== 1'b0) begin errors++; $display("FAIL reset_data_ack got %b want 0", bus.out_data_ack); end
    checks++; if (bus.out_mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", bus.out_mem_req_valid); end
    checks++; if (bus.out_mem_req_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", bus.out_mem_req_write); end
    checks++; if (bus.out_mem_req_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.out_mem_req_addr); end
    checks++; if (bus.out_mem_req_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.out_mem_req_wdata); end
    checks++; if (bus.out_icache_rdata !== '0) begin errors++; $display("FAIL reset_icache_rdata got %h want 0", bus.out_icache_rdata); end
    checks++; if (bus.out_data_rdata !== '0) begin errors++; $display("FAIL reset_data_rdata got %h want 0", bus.out_data_rdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lone_icache();
    int s0, i0, d0, w;
    bit ok;
    line_t aa;
    aa = {32{8'hAA}};
    s0 = strobe_cnt; i0 = iack_cnt; d0 = dack_cnt;
    bus.in_icache_req_valid = 1'b1;
    bus.in_icache_req_addr  = 64'h1_0007;
    tick();
    wait_strobe(20, ok, w);
    checks++; if (!ok || w != 0) begin errors++; $display("FAIL lone_strobe_latency got ok=%0b wait=%0d want ok=1 wait=0", ok, w); end
    checks++; if (bus.out_mem_req_addr !== 64'h1_0000) begin errors++; $display("FAIL lone_addr got %h want 10000", bus.out_mem_req_addr); end
    checks++; if (bus.out_mem_req_write !== 1'b0) begin errors++; $display("FAIL lone_write got %b want 0", bus.out_mem_req_write); end
    repeat (3) tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = aa;
    tick();
    bus.in_mem_ack = 1'b0;
    bus.in_mem_rdata = rand_line();
    checks++; if (bus.out_icache_ack !== 1'b1) begin errors++; $display("FAIL lone_ack got %b want 1", bus.out_icache_ack); end
    checks++; if (bus.out_icache_rdata !== aa) begin errors++; $display("FAIL lone_rdata got %h want %h", bus.out_icache_rdata, aa); end
    // Valid stays high through the ack cycle: it must not be granted again.
    tick();
    bus.in_icache_req_valid = 1'b0;
    checks++; if (bus.out_icache_ack !== 1'b0) begin errors++; $display("FAIL lone_ack_pulse got %b want 0", bus.out_icache_ack); end
    repeat (6) tick();
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL lone_strobe_count got %0d want 1", strobe_cnt - s0); end
    checks++; if (iack_cnt - i0 != 1 || dack_cnt - d0 != 0) begin errors++; $display("FAIL lone_ack_counts got i=%0d d=%0d want i=1 d=0", iack_cnt - i0, dack_cnt - d0); end
    checks++; if (bus.out_icache_rdata !== aa) begin errors++; $display("FAIL lone_rdata_hold got %h want %h", bus.out_icache_rdata, aa); end
  endtask

  task automatic test_collision();
    int w;
    bit ok;
    line_t wd, r;
    do_reset();
    wd = rand_line();
    bus.in_icache_req_valid = 1'b1;
    bus.in_icache_req_addr  = 64'h40;
    bus.in_data_req_valid   = 1'b1;
    bus.in_data_req_write   = 1'b1;
    bus.in_data_req_addr    = 64'h80;
    bus.in_data_req_wdata   = wd;
    tick();
    wait_strobe(20, ok, w);
    checks++; if (!ok || w != 0) begin errors++; $display("FAIL tie_first_strobe got ok=%0b wait=%0d want ok=1 wait=0", ok, w); end
    checks++; if (bus.out_mem_req_write !== 1'b1) begin errors++; $display("FAIL tie_first_write got %b want 1", bus.out_mem_req_write); end
    checks++; if (bus.out_mem_req_addr !== 64'h80) begin errors++; $display("FAIL tie_first_addr got %h want 80", bus.out_mem_req_addr); end
    checks++; if (bus.out_mem_req_wdata !== wd) begin errors++; $display("FAIL tie_first_wdata got %h want %h", bus.out_mem_req_wdata, wd); end
    repeat (2) tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = rand_line();
    tick();
    bus.in_mem_ack = 1'b0;
    checks++; if (bus.out_data_ack !== 1'b1 || bus.out_icache_ack !== 1'b0) begin errors++; $display("FAIL tie_data_ack got d=%b i=%b want d=1 i=0", bus.out_data_ack, bus.out_icache_ack); end
    checks++; if (bus.out_data_rdata !== '0) begin errors++; $display("FAIL tie_write_rdata got %h want 0", bus.out_data_rdata); end
    bus.in_data_req_valid = 1'b0;
    tick();
    wait_strobe(20, ok, w);
    checks++; if (!ok || w != 0) begin errors++; $display("FAIL tie_second_strobe got ok=%0b wait=%0d want ok=1 wait=0", ok, w); end
    checks++; if (bus.out_mem_req_addr !== 64'h40 || bus.out_mem_req_write !== 1'b0) begin errors++; $display("FAIL tie_second_req got addr=%h w=%b want addr=40 w=0", bus.out_mem_req_addr, bus.out_mem_req_write); end
    r = rand_line();
    tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = r;
    tick();
    bus.in_mem_ack = 1'b0;
    checks++; if (bus.out_icache_ack !== 1'b1 || bus.out_data_ack !== 1'b0) begin errors++; $display("FAIL tie_icache_ack got i=%b d=%b want i=1 d=0", bus.out_icache_ack, bus.out_data_ack); end
    checks++; if (bus.out_icache_rdata !== r) begin errors++; $display("FAIL tie_icache_rdata got %h want %h", bus.out_icache_rdata, r); end
    bus.in_icache_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_busy();
    int s0, i0, d0;
    addr_t a;
    line_t r;
    s0 = strobe_cnt; i0 = iack_cnt; d0 = dack_cnt;
    a = rand_addr();
    r = rand_line();
    bus.in_mem_busy       = 1'b1;
    bus.in_data_req_valid = 1'b1;
    bus.in_data_req_write = 1'b0;
    bus.in_data_req_addr  = a;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_mem_req_valid !== 1'b0) begin errors++; $display("FAIL busy_hold_%0d got %b want 0", i, bus.out_mem_req_valid); end
      bus.in_mem_ack = (i == 1);  // stray ack while still issuing
      tick();
    end
    bus.in_mem_ack  = 1'b0;
    bus.in_mem_busy = 1'b0;
    #1;
    checks++; if (bus.out_mem_req_valid !== 1'b1) begin errors++; $display("FAIL busy_release got %b want 1", bus.out_mem_req_valid); end
    checks++; if (bus.out_mem_req_addr !== (a & AMask)) begin errors++; $display("FAIL busy_addr got %h want %h", bus.out_mem_req_addr, a & AMask); end
    tick();
    checks++; if (bus.out_mem_req_valid !== 1'b0) begin errors++; $display("FAIL busy_single_strobe got %b want 0", bus.out_mem_req_valid); end
    tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = r;
    tick();
    bus.in_mem_ack = 1'b0;
    checks++; if (bus.out_data_ack !== 1'b1 || bus.out_data_rdata !== r) begin errors++; $display("FAIL busy_data_ack got ack=%b rdata=%h want ack=1 rdata=%h", bus.out_data_ack, bus.out_data_rdata, r); end
    bus.in_data_req_valid = 1'b0;
    tick();
    checks++; if (strobe_cnt - s0 != 1 || dack_cnt - d0 != 1 || iack_cnt - i0 != 0) begin errors++; $display("FAIL busy_counts got s=%0d d=%0d i=%0d want s=1 d=1 i=0", strobe_cnt - s0, dack_cnt - d0, iack_cnt - i0); end
  endtask

  task automatic test_latched();
    addr_t a;
    line_t wd;
    a = rand_addr();
    wd = rand_line();
    bus.in_data_req_valid = 1'b1;
    bus.in_data_req_write = 1'b1;
    bus.in_data_req_addr  = a;
    bus.in_data_req_wdata = wd;
    tick();
    bus.in_data_req_addr  = ~a;
    bus.in_data_req_wdata = ~wd;
    bus.in_data_req_write = 1'b0;
    #1;
    checks++; if (bus.out_mem_req_valid !== 1'b1) begin errors++; $display("FAIL latch_strobe got %b want 1", bus.out_mem_req_valid); end
    checks++; if (bus.out_mem_req_addr !== (a & AMask)) begin errors++; $display("FAIL latch_addr got %h want %h", bus.out_mem_req_addr, a & AMask); end
    checks++; if (bus.out_mem_req_wdata !== wd) begin errors++; $display("FAIL latch_wdata got %h want %h", bus.out_mem_req_wdata, wd); end
    checks++; if (bus.out_mem_req_write !== 1'b1) begin errors++; $display("FAIL latch_write got %b want 1", bus.out_mem_req_write); end
    repeat (2) tick();
    bus.in_mem_ack = 1'b1;
    tick();
    bus.in_mem_ack = 1'b0;
    checks++; if (bus.out_data_ack !== 1'b1) begin errors++; $display("FAIL latch_ack got %b want 1", bus.out_data_ack); end
    bus.in_data_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int i0, d0, w;
    bit ok;
    addr_t a;
    line_t r;
    i0 = iack_cnt; d0 = dack_cnt;
    bus.in_icache_req_valid = 1'b1;
    bus.in_icache_req_addr  = rand_addr();
    tick();
    wait_strobe(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL rstwait_strobe got timeout want strobe"); end
    tick();
    rst_n = 1'b0;
    bus.in_icache_req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = rand_line();
    tick();
    bus.in_mem_ack = 1'b0;
    repeat (2) tick();
    checks++; if (iack_cnt - i0 != 0 || dack_cnt - d0 != 0) begin errors++; $display("FAIL rstwait_no_ack got i=%0d d=%0d want 0 0", iack_cnt - i0, dack_cnt - d0); end
    checks++; if (bus.out_icache_rdata !== '0 || bus.out_data_rdata !== '0) begin errors++; $display("FAIL rstwait_rdata got i=%h d=%h want 0", bus.out_icache_rdata, bus.out_data_rdata); end
    checks++; if (bus.out_mem_req_valid !== 1'b0 || bus.out_mem_req_addr !== '0) begin errors++; $display("FAIL rstwait_mem got v=%b a=%h want 0", bus.out_mem_req_valid, bus.out_mem_req_addr); end
    a = rand_addr();
    r = rand_line();
    bus.in_data_req_valid = 1'b1;
    bus.in_data_req_write = 1'b0;
    bus.in_data_req_addr  = a;
    tick();
    wait_strobe(20, ok, w);
    checks++; if (!ok || w != 0 || bus.out_mem_req_addr !== (a & AMask)) begin errors++; $display("FAIL rstwait_next_req got ok=%0b wait=%0d addr=%h want ok=1 wait=0 addr=%h", ok, w, bus.out_mem_req_addr, a & AMask); end
    tick();
    bus.in_mem_ack = 1'b1;
    bus.in_mem_rdata = r;
    tick();
    bus.in_mem_ack = 1'b0;
    checks++; if (bus.out_data_ack !== 1'b1 || bus.out_data_rdata !== r) begin errors++; $display("FAIL rstwait_next_ack got ack=%b rdata=%h want ack=1 rdata=%h", bus.out_data_ack, bus.out_data_rdata, r); end
    bus.in_data_req_valid = 1'b0;
    tick();
  endtask

  // Both sides request continuously; model: on a tie the side not served last wins.
  task automatic test_alternate();
    addr_t ia, da, exp_addr;
    logic dw, exp_write;
    line_t dwd, r, exp_irdata, exp_drdata;
    int model_last, winner, tries, d;
    bit ok;
    do_reset();
    model_last = 0;
    exp_irdata = '0;
    exp_drdata = '0;
    ia = rand_addr(); da = rand_addr(); dw = 1'($urandom_range(0, 1)); dwd = rand_line();
    bus.in_icache_req_valid = 1'b1;
    bus.in_icache_req_addr  = ia;
    bus.in_data_req_valid   = 1'b1;
    bus.in_data_req_write   = dw;
    bus.in_data_req_addr    = da;
    bus.in_data_req_wdata   = dwd;
    for (int t = 0; t < 10; t++) begin
      winner = (model_last == 0) ? 1 : 0;
      model_last = winner;
      exp_addr  = ((winner == 1) ? da : ia) & AMask;
      exp_write = (winner == 1) ? dw : 1'b0;
      ok = 1'b0;
      tries = 0;
      while (!ok && tries < 30) begin
        tick();
        bus.in_mem_busy = (tries < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (bus.out_mem_req_valid === 1'b1) ok = 1'b1;
        tries++;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL alt_strobe_%0d got timeout want strobe", t);
        idle_inputs();
        return;
      end
      checks++; if (bus.out_mem_req_addr !== exp_addr) begin errors++; $display("FAIL alt_addr_%0d got %h want %h", t, bus.out_mem_req_addr, exp_addr); end
      checks++; if (bus.out_mem_req_write !== exp_write) begin errors++; $display("FAIL alt_write_%0d got %b want %b", t, bus.out_mem_req_write, exp_write); end
      if (winner == 1 && dw) begin
        checks++; if (bus.out_mem_req_wdata !== dwd) begin errors++; $display("FAIL alt_wdata_%0d got %h want %h", t, bus.out_mem_req_wdata, dwd); end
      end
      d = $urandom_range(1, 4);
      repeat (d) tick();
      r = rand_line();
      bus.in_mem_ack = 1'b1;
      bus.in_mem_rdata = r;
      tick();
      bus.in_mem_ack = 1'b0;
      if (winner == 0) exp_irdata = r;
      else if (!dw) exp_drdata = r;
      checks++; if (bus.out_icache_ack !== (winner == 0) || bus.out_data_ack !== (winner == 1)) begin errors++; $display("FAIL alt_ack_%0d got i=%b d=%b want winner=%0d", t, bus.out_icache_ack, bus.out_data_ack, winner); end
      checks++; if (bus.out_icache_rdata !== exp_irdata || bus.out_data_rdata !== exp_drdata) begin errors++; $display("FAIL alt_rdata_%0d got i=%h d=%h want i=%h d=%h", t, bus.out_icache_rdata, bus.out_data_rdata, exp_irdata, exp_drdata); end
      if (t == 9) begin
        bus.in_icache_req_valid = 1'b0;
        bus.in_data_req_valid   = 1'b0;
      end else if (winner == 0) begin
        ia = rand_addr();
        bus.in_icache_req_addr = ia;
      end else begin
        da = rand_addr(); dw = 1'($urandom_range(0, 1)); dwd = rand_line();
        bus.in_data_req_write = dw;
        bus.in_data_req_addr  = da;
        bus.in_data_req_wdata = dwd;
      end
    end
    repeat (3) tick();
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL ack_overlap got %0d cycles want 0", overlap_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_lone_icache();
    test_collision();
    test_busy();
    test_latched();
    test_reset_in_wait();
    test_alternate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snow64_mem_access_arbiter.md
Name: snow64_mem_access_arbiter

Overview:
- Shares the single external memory port between the instruction cache (line refills) and the LAR-file data path (line loads/stores).
- Sits between both caches and the memory controller.
- Fetch stalls while a load/store is in flight, so fetch and data requests collide at line boundaries. This block serialises them with round-robin fairness and returns responses to the winner.

Parameters:
- WIDTH_ADDR, 64, byte address width of all request addresses.
- WIDTH_LINE, 256, width of one cache line transferred per transaction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_icache_req_valid  in  1  icache line-read request, held until ack
- in_icache_req_addr  in  WIDTH_ADDR  line address, low 5 bits ignored
- out_icache_ack  out  1  one-cycle pulse: read data valid
- out_icache_rdata  out  WIDTH_LINE  returned line
- in_data_req_valid  in  1  data-side request, held until ack
- in_data_req_write  in  1  1 = line write, 0 = line read
- in_data_req_addr  in  WIDTH_ADDR  line address, low 5 bits ignored
- in_data_req_wdata  in  WIDTH_LINE  write line
- out_data_ack  out  1  one-cycle pulse: read data valid / write done
- out_data_rdata  out  WIDTH_LINE  returned line (reads only)
- out_mem_req_valid  out  1  one-cycle issue strobe to memory
- out_mem_req_write  out  1  write flag
- out_mem_req_addr  out  WIDTH_ADDR  line-aligned address, low 5 bits forced 0
- out_mem_req_wdata  out  WIDTH_LINE  write line
- in_mem_busy  in  1  memory cannot accept an issue this cycle
- in_mem_ack  in  1  one-cycle completion pulse
- in_mem_rdata  in  WIDTH_LINE  read line, valid with in_mem_ack

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state StIdle; last_grant = Icache, so data wins the first tie.
  - Any in-flight transaction is abandoned; no ack is ever produced for it.
- States:
  - StIdle: sample both requests.
    - Exactly one valid: grant it.
    - Both valid: grant the requester that is not last_grant.
    - On grant: latch requester id, write flag (icache always 0), address with low 5 bits cleared, and wdata. Update last_grant. Go to StIssue.
    - No request: stay.
  - StIssue: if !in_mem_busy, assert out_mem_req_valid for exactly this cycle with the latched fields, then go to StWait. Otherwise hold the strobe low and stay.
  - StWait: on in_mem_ack, register in_mem_rdata into the winner's rdata output and pulse the winner's ack next cycle. Go to StIdle in that same ack cycle.
  - in_mem_ack in StIdle or StIssue is ignored.
- Latency:
  - Request asserted at cycle N in StIdle → mem strobe at N+1 if not busy.
  - in_mem_ack at cycle M → requester ack at M+1.
  - Best-case new grant at M+1, because StIdle samples in the ack cycle. The acked requester must drop valid in the ack cycle, so its stale valid is seen once. The arbiter therefore suppresses re-grant of the just-acked requester for the cycle its ack is high.
- Latched-request rule: requester fields are captured at grant. Later changes, or dropping req_valid before ack, do not alter the in-flight transaction (dropping is a protocol error, not checked).
- rdata outputs hold their last value between acks. Write acks leave out_data_rdata unchanged.
- Acks never overlap: at most one of out_icache_ack / out_data_ack is high in any cycle.
- The losing requester waits at most one full transaction (round-robin).

Decomposition:
- Shared package PkgSnow64MemArbiter:
  - requester enum {Icache, Data}
  - state enum {StIdle, StIssue, StWait}
  - packed structs PortIn/PortOut for the icache, data and memory sides
  - line-offset constant (5)
- One natural sub-module: snow64_rr_arbiter2, a 2-way round-robin grant with a last_grant register and enable. Everything else stays in the top module.

Test Plan:
- Lone icache read addr 0x1_0007, mem_busy=0, mem_ack 3 cycles after strobe, rdata=0xAA.. → strobe one cycle after request, mem addr 0x1_0000, write=0, out_icache_ack one pulse with rdata 0xAA.., out_data_ack stays 0.
- Simultaneous icache read 0x40 and data write 0x80 straight out of reset → data first (strobe write=1, addr 0x80, wdata passed through), data ack, then icache strobe addr 0x40; then repeat both → icache served first.
- in_mem_busy high for 4 cycles in StIssue → strobe withheld, then exactly one strobe cycle; single ack.
- Data requester changes addr/wdata after grant → memory sees the originally latched values.
- rst_n pulled low in StWait, then mem_ack arrives after release → no ack pulses, all outputs 0, next request served normally.
- Continuous requests from both for 10 transactions → grants strictly alternate, never two acks in one cycle.
